// File: rtl/dmem_access_ctrl_if.sv
// dmem_access_ctrl_if: pipeline request/response handshake plus DataMemory strobes for dmem_access_ctrl
interface dmem_access_ctrl_if #(parameter int ADDR_W = 20, parameter int DATA_W = 20);
  logic req_valid, req_ready, req_write, req_memtoreg;
  logic [ADDR_W-1:0] req_addr, address;
  logic [DATA_W-1:0] req_wdata, rsp_data, writeData, readData;
  logic rsp_valid, rsp_ready, rsp_write, rsp_memtoreg, rsp_err;
  logic memwrite, memread, memtoreg;
  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_memtoreg, rsp_ready, readData,
    input req_ready, rsp_valid, rsp_data, rsp_write, rsp_memtoreg, rsp_err,
    input address, writeData, memwrite, memread, memtoreg
  );
  modport slave (
    input req_valid, req_write, req_addr, req_wdata, req_memtoreg, rsp_ready, readData,
    output req_ready, rsp_valid, rsp_data, rsp_write, rsp_memtoreg, rsp_err,
    output address, writeData, memwrite, memread, memtoreg
  );
endinterface

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: one-outstanding load/store initiator toward DataMemory; DMEM_READBACK_CHECK_EN adds a store readback verify
module dmem_access_ctrl #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 20,
  parameter int MEM_WORDS = 32,
  parameter int READ_LATENCY = 1
) (
  input logic clk,
  input logic rst,
  dmem_access_ctrl_if.slave bus
);
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD = 3'd2, RSP = 3'd3;
`ifdef DMEM_READBACK_CHECK_EN
  localparam logic [2:0] VFY = 3'd4;
`endif
  logic [2:0] state, cnt;
  logic oor;
  assign oor = bus.req_addr >= ADDR_W'(MEM_WORDS);
  assign bus.req_ready = state == IDLE && !rst;
  assign bus.rsp_valid = state == RSP;
  assign bus.memwrite = state == WR;
`ifdef DMEM_READBACK_CHECK_EN
  assign bus.memread = state == RD || state == VFY;
`else
  assign bus.memread = state == RD;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      bus.address <= '0;
      bus.writeData <= '0;
      bus.memtoreg <= 1'b0;
      bus.rsp_data <= '0;
      bus.rsp_write <= 1'b0;
      bus.rsp_memtoreg <= 1'b0;
      bus.rsp_err <= 1'b0;
    end else
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.rsp_data <= '0;
          bus.rsp_write <= bus.req_write;
          bus.rsp_memtoreg <= bus.req_memtoreg;
          bus.rsp_err <= oor;
          cnt <= 3'(READ_LATENCY);
          state <= oor ? RSP : bus.req_write ? WR : RD;
          // out-of-range requests leave the memory-facing registers untouched
          if (!oor) begin
            bus.address <= bus.req_addr;
            bus.memtoreg <= bus.req_memtoreg;
            if (bus.req_write) bus.writeData <= bus.req_wdata;
          end
        end
`ifdef DMEM_READBACK_CHECK_EN
        WR: begin
          cnt <= 3'(READ_LATENCY);
          state <= VFY;
        end
        VFY: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            bus.rsp_err <= bus.readData != bus.writeData;
            state <= RSP;
          end
        end
`else
        WR: state <= RSP;
`endif
        RD: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            bus.rsp_data <= bus.readData;
            state <= RSP;
          end
        end
        RSP: if (bus.rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: vector table run on a READ_LATENCY=3 instance with a READ_LATENCY=1 instance mirroring its requests
module tb_dmem_access_ctrl;
  localparam int RL = 3;
`ifdef DMEM_READBACK_CHECK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  typedef struct {
    logic wr;
    logic [19:0] addr, data;
    logic m2r;
    logic [19:0] exp_data;
    logic exp_err;
  } vec_t;
  typedef struct {
    logic [19:0] data, waddr, wdata, raddr;
    logic err, wr, m2r, both;
    int wcnt, rcnt, lat;
  } obs_t;
  logic clk = 1'b0, rst = 1'b1, corrupt = 1'b0;
  int n_vec = 0, n_bad = 0;
  vec_t tbl [14];
  dmem_access_ctrl_if #(.ADDR_W(20), .DATA_W(20)) ia ();
  dmem_access_ctrl_if #(.ADDR_W(20), .DATA_W(20)) ib ();
  dmem_access_ctrl #(.ADDR_W(20), .DATA_W(20), .MEM_WORDS(32), .READ_LATENCY(RL)) da (.clk(clk), .rst(rst), .bus(ia));
  dmem_access_ctrl #(.ADDR_W(20), .DATA_W(20), .MEM_WORDS(32), .READ_LATENCY(1)) db (.clk(clk), .rst(rst), .bus(ib));
  always #5 clk = ~clk;
  assign ib.req_valid = ia.req_valid;
  assign ib.req_write = ia.req_write;
  assign ib.req_addr = ia.req_addr;
  assign ib.req_wdata = ia.req_wdata;
  assign ib.req_memtoreg = ia.req_memtoreg;
  assign ib.rsp_ready = ia.rsp_ready;
  logic [19:0] mem_a [32];
  logic [19:0] mem_b [32];
  logic [2:0] run_a = 3'd0;
  always @(posedge clk) begin
    if (ia.memwrite) mem_a[ia.address[4:0]] <= ia.writeData;
    if (ib.memwrite) mem_b[ib.address[4:0]] <= ib.writeData;
    run_a <= ia.memread ? run_a + 3'd1 : 3'd0;
  end
  // data only becomes valid after RL-1 edges of continuous memread
  assign ia.readData = (ia.memread && run_a >= 3'(RL - 1)) ? mem_a[ia.address[4:0]] ^ {19'd0, corrupt} : 20'hBAD00;
  assign ib.readData = ib.memread ? mem_b[ib.address[4:0]] ^ {19'd0, corrupt} : 20'hBAD00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, output obs_t oa, output obs_t ob);
    int k;
    bit got_a, got_b;
    oa = '{default: 0};
    ob = '{default: 0};
    @(negedge clk);
    ia.req_valid = 1'b1;
    ia.req_write = v.wr;
    ia.req_addr = v.addr;
    ia.req_wdata = v.data;
    ia.req_memtoreg = v.m2r;
    ia.rsp_ready = 1'b1;
    k = 0;
    while (!ia.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!ia.req_ready) chk("accept_timeout", 32'(ia.req_ready), 32'd1);
    @(negedge clk);
    ia.req_valid = 1'b0;
    got_a = 0;
    got_b = 0;
    for (int c = 1; c <= 40 && !got_a; c++) begin
      if (ia.memwrite) begin
        oa.wcnt++;
        oa.waddr = ia.address;
        oa.wdata = ia.writeData;
      end
      if (ia.memread) begin
        oa.rcnt++;
        oa.raddr = ia.address;
      end
      if (ia.memwrite && ia.memread) oa.both = 1'b1;
      if (!got_b) begin
        if (ib.memwrite) begin
          ob.wcnt++;
          ob.waddr = ib.address;
          ob.wdata = ib.writeData;
        end
        if (ib.memread) begin
          ob.rcnt++;
          ob.raddr = ib.address;
        end
        if (ib.memwrite && ib.memread) ob.both = 1'b1;
        if (ib.rsp_valid) begin
          got_b = 1;
          ob.lat = c;
          ob.data = ib.rsp_data;
          ob.err = ib.rsp_err;
          ob.wr = ib.rsp_write;
          ob.m2r = ib.rsp_memtoreg;
        end
      end
      if (ia.rsp_valid) begin
        got_a = 1;
        oa.lat = c;
        oa.data = ia.rsp_data;
        oa.err = ia.rsp_err;
        oa.wr = ia.rsp_write;
        oa.m2r = ia.rsp_memtoreg;
      end else @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic check_obs(input string tag, input obs_t o, input vec_t v, input int rl);
    int el, er;
    el = v.exp_err ? 1 : v.wr ? 2 + (RB ? rl : 0) : rl + 1;
    er = v.exp_err ? 0 : v.wr ? (RB ? rl : 0) : rl;
    chk({tag, ".lat"}, 32'(o.lat), 32'(el));
    chk({tag, ".data"}, 32'(o.data), 32'(v.exp_data));
    chk({tag, ".err"}, 32'(o.err), 32'(v.exp_err));
    chk({tag, ".write"}, 32'(o.wr), 32'(v.wr));
    chk({tag, ".memtoreg"}, 32'(o.m2r), 32'(v.m2r));
    chk({tag, ".wcnt"}, 32'(o.wcnt), 32'(v.wr && !v.exp_err));
    chk({tag, ".rcnt"}, 32'(o.rcnt), 32'(er));
    chk({tag, ".both"}, 32'(o.both), 32'd0);
    if (v.wr && !v.exp_err) begin
      chk({tag, ".waddr"}, 32'(o.waddr), 32'(v.addr));
      chk({tag, ".wdata"}, 32'(o.wdata), 32'(v.data));
    end
    if (er > 0) chk({tag, ".raddr"}, 32'(o.raddr), 32'(v.addr));
  endtask

  task automatic txn_both(input string tag, input vec_t v);
    obs_t oa, ob;
    run_txn(v, oa, ob);
    check_obs({tag, ".a"}, oa, v, RL);
    check_obs({tag, ".b"}, ob, v, 1);
    chk({tag, ".rsp_valid_after"}, 32'(ia.rsp_valid), 32'd0);
    chk({tag, ".req_ready_after"}, 32'(ia.req_ready), 32'd1);
  endtask

  initial begin
    int k;
    tbl[0] = '{1'b1, 20'd5, 20'd2, 1'b0, 20'd0, 1'b0};
    tbl[1] = '{1'b0, 20'd5, 20'd0, 1'b1, 20'd2, 1'b0};
    tbl[2] = '{1'b1, 20'd8, 20'd12, 1'b0, 20'd0, 1'b0};
    tbl[3] = '{1'b0, 20'd8, 20'd0, 1'b0, 20'd12, 1'b0};
    tbl[4] = '{1'b0, 20'd40, 20'd0, 1'b0, 20'd0, 1'b1};
    tbl[5] = '{1'b1, 20'd0, 20'h12345, 1'b1, 20'd0, 1'b0};
    tbl[6] = '{1'b1, 20'd32, 20'd7, 1'b0, 20'd0, 1'b1};
    tbl[7] = '{1'b0, 20'd0, 20'd0, 1'b1, 20'h12345, 1'b0};
    tbl[8] = '{1'b1, 20'd31, 20'hFFFFF, 1'b1, 20'd0, 1'b0};
    tbl[9] = '{1'b0, 20'd31, 20'd0, 1'b0, 20'hFFFFF, 1'b0};
    tbl[10] = '{1'b0, 20'h80005, 20'd0, 1'b1, 20'd0, 1'b1};
    tbl[11] = '{1'b1, 20'h80008, 20'hAAAAA, 1'b0, 20'd0, 1'b1};
    tbl[12] = '{1'b0, 20'd8, 20'd0, 1'b1, 20'd12, 1'b0};
    tbl[13] = '{1'b0, 20'd5, 20'd0, 1'b0, 20'd2, 1'b0};
    ia.req_valid = 1'b0;
    ia.req_write = 1'b0;
    ia.req_addr = '0;
    ia.req_wdata = '0;
    ia.req_memtoreg = 1'b0;
    ia.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset.req_ready", 32'(ia.req_ready), 32'd0);
    chk("reset.rsp_valid", 32'(ia.rsp_valid), 32'd0);
    chk("reset.strobes", 32'({ia.memwrite, ia.memread, ia.memtoreg}), 32'd0);
    chk("reset.address", 32'(ia.address), 32'd0);
    chk("reset.writeData", 32'(ia.writeData), 32'd0);
    chk("reset.rsp", 32'({ia.rsp_data, ia.rsp_err, ia.rsp_write, ia.rsp_memtoreg}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset.req_ready", 32'(ia.req_ready), 32'd1);
    for (int i = 0; i < 14; i++) txn_both($sformatf("vec%0d", i), tbl[i]);
    // response back-pressure with a competing request that must be ignored
    @(negedge clk);
    ia.req_valid = 1'b1;
    ia.req_write = 1'b0;
    ia.req_addr = 20'd8;
    ia.req_memtoreg = 1'b1;
    ia.rsp_ready = 1'b0;
    @(negedge clk);
    ia.req_valid = 1'b0;
    k = 0;
    while (!ia.rsp_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("hold.rsp_seen", 32'(ia.rsp_valid), 32'd1);
    ia.req_valid = 1'b1;
    ia.req_write = 1'b1;
    ia.req_wdata = 20'd99;
    for (int h = 0; h < 4; h++) begin
      chk($sformatf("hold%0d.rsp_valid", h), 32'(ia.rsp_valid), 32'd1);
      chk($sformatf("hold%0d.rsp_data", h), 32'(ia.rsp_data), 32'd12);
      chk($sformatf("hold%0d.memtoreg", h), 32'(ia.rsp_memtoreg), 32'd1);
      chk($sformatf("hold%0d.req_ready", h), 32'(ia.req_ready), 32'd0);
      chk($sformatf("hold%0d.memwrite", h), 32'({ia.memwrite, ib.memwrite}), 32'd0);
      chk($sformatf("hold%0d.b_rsp", h), 32'({ib.rsp_valid, ib.rsp_data}), 32'({1'b1, 20'd12}));
      @(negedge clk);
    end
    ia.req_valid = 1'b0;
    ia.rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold.release.rsp_valid", 32'(ia.rsp_valid), 32'd0);
    chk("hold.release.req_ready", 32'(ia.req_ready), 32'd1);
    txn_both("hold.reload", tbl[12]);
    // reset in the middle of a load
    ia.req_valid = 1'b1;
    ia.req_write = 1'b0;
    ia.req_addr = 20'd5;
    @(negedge clk);
    ia.req_valid = 1'b0;
    chk("rstrd.memread", 32'(ia.memread), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstrd.memread_drop", 32'({ia.memread, ib.memread}), 32'd0);
    chk("rstrd.rsp_valid", 32'({ia.rsp_valid, ib.rsp_valid}), 32'd0);
    chk("rstrd.req_ready", 32'(ia.req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < RL + 2; c++) begin
      @(negedge clk);
      chk($sformatf("rstrd%0d.no_rsp", c), 32'({ia.rsp_valid, ib.rsp_valid, ia.memread}), 32'd0);
    end
    chk("rstrd.req_ready_after", 32'(ia.req_ready), 32'd1);
    chk("rstrd.address", 32'(ia.address), 32'd0);
    // corrupted readback only flags the store when the verify stage exists
    corrupt = 1'b1;
    txn_both("corrupt", '{1'b1, 20'd3, 20'd5, 1'b0, 20'd0, RB});
    corrupt = 1'b0;
    txn_both("after_corrupt", '{1'b0, 20'd3, 20'd0, 1'b1, 20'd5, 1'b0});
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
